lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Multi-cycle load/store sequencer for the single-cycle RV32 core. Freezes the core
//  (stall) while a data-bus access is in flight, forms byte lanes, aligns and extends
//  load data, and drives the 3:1 result mux select: 00 ALU, 01 MEM, 10 PC+4.
//  Sits between the decoder/ALU outputs and the data-memory bus.
// PARAMETERS
//  XLEN     32   data/address width
//  TIMEOUT  255  max cycles in REQ+WAIT before abort (1..2^16-1)
// PORTS
//  clk            in   1     core clock
//  rst            in   1     synchronous, active-high reset
//  mem_read       in   1     decoded load
//  mem_write      in   1     decoded store
//  funct3         in   3     access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  addr           in   XLEN  effective address from ALU
//  wdata          in   XLEN  store data (rs2)
//  result_src_in  in   2     result select from main decoder
//  stall          out  1     hold PC and regfile write
//  result_sel     out  2     to result mux31 cntrl
//  load_data      out  XLEN  aligned, extended load result
//  access_err     out  1     1-cycle pulse: misaligned or illegal funct3
//  timeout_err    out  1     sticky bus timeout flag
//  bus_req        out  1     request; held until bus_gnt
//  bus_we         out  1     1 = write
//  bus_addr       out  XLEN  word address ({addr[XLEN-1:2],2'b00})
//  bus_wdata      out  XLEN  lane-replicated store data
//  bus_be         out  4     byte enables
//  bus_gnt        in   1     request accepted this cycle
//  bus_rvalid     in   1     read data valid (>=1 cycle after gnt)
//  bus_rdata      in   XLEN  read data
// BEHAVIOUR
//  Reset: state IDLE; bus_req/bus_we/bus_be/bus_addr/bus_wdata/load_data/access_err/timeout_err = 0.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE:
//   IDLE: legal access -> latch addr/wdata/funct3/dir, stall=1 (combinational), go REQ.
//         Illegal (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0; funct3 011/110/111) ->
//         access_err=1 for 1 cycle, stall=0, no bus activity, stay IDLE.
//         mem_read & mem_write both high: read wins, write ignored.
//   REQ:  bus_req=1, outputs stable from latches; stall=1. gnt & write -> DONE; gnt & read -> WAIT.
//   WAIT: stall=1; bus_rvalid -> register extended load_data, go DONE.
//   DONE: stall=0 for exactly 1 cycle (instruction retires); load -> result_sel=01. Then IDLE.
//  result_sel = result_src_in in all other states (11 passes through; mux gives 0).
//  Min latency: store 3 cycles (IDLE,REQ,DONE); load 4 (IDLE,REQ,WAIT,DONE).
//  Lanes: SB be=4'b0001<<addr[1:0], wdata={4{b}}; SH be=4'b0011<<addr[1:0], {2{h}}; SW be=4'hF.
//  Loads: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Timeout: counter cleared on IDLE->REQ; reaching TIMEOUT in REQ/WAIT -> timeout_err=1
//   (sticky until rst), bus_req drops, load_data=0, go DONE.
//  bus_rvalid outside WAIT ignored; load_data holds last value outside DONE.
//  rst mid-access: IDLE next edge, bus_req=0; late rvalid ignored.
// STRUCTURE
//  Package riscv_lsu_pkg: state encoding, funct3 constants, RES_ALU/RES_MEM/RES_PC4.
//  Sub-module lsu_align (combinational): be/wdata lane forming + load extraction/extension.
// TESTING
//  1 SW addr=0x100 wdata=0xDEADBEEF, gnt immediate -> be=F, stall 1,1,0, bus_we=1.
//  2 LB addr=0x103, rdata=0x80FF_FFFF 1 cycle after gnt -> load_data=0xFFFFFF80, result_sel=01 in DONE.
//  3 LHU addr=0x102, rdata=0x8001_0000 -> load_data=0x00008001; SH addr=0x102 wdata=0x1234 -> be=1100, bus_wdata=0x12341234.
//  4 LW addr=0x101 -> access_err 1-cycle pulse, bus_req never 1, stall=0.
//  5 TIMEOUT=4, gnt never -> timeout_err=1 after 4 REQ cycles, then DONE, load_data=0.
//  6 rst in WAIT, rvalid next cycle -> state IDLE, load_data=0, stall=0.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Misaligned access or a funct3 with no load/store meaning.
    function automatic logic access_illegal(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic w_bad;
        case (funct3)
            F3_B, F3_BU: w_bad = 1'b0;
            F3_H, F3_HU: w_bad = addr_lo[0];
            F3_W:        w_bad = (addr_lo != 2'b00);
            default:     w_bad = 1'b1;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane forming for stores and byte/half extraction with extension for loads.
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_st_funct3,
    input  logic [1:0]      i_st_addr_lo,
    input  logic [XLEN-1:0] i_st_wdata,
    output logic [3:0]      o_st_be,
    output logic [XLEN-1:0] o_st_wdata,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_addr_lo,
    input  logic [XLEN-1:0] i_ld_rdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [XLEN-1:0] w_ld_shifted;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;

    // Store side: replicate the datum into every lane so the enables alone pick the target.
    always_comb begin
        o_st_be    = 4'hF;
        o_st_wdata = i_st_wdata;
        case (i_st_funct3[1:0])
            2'b00: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {(XLEN/8){i_st_wdata[7:0]}};
            end
            2'b01: begin
                o_st_be    = 4'b0011 << i_st_addr_lo;
                o_st_wdata = {(XLEN/16){i_st_wdata[15:0]}};
            end
            default: begin
                o_st_be    = 4'hF;
                o_st_wdata = i_st_wdata;
            end
        endcase
    end

    assign w_ld_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
    assign w_ld_byte    = w_ld_shifted[7:0];
    assign w_ld_half    = w_ld_shifted[15:0];

    // Load side: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
            F3_H:    o_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
            F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
            F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: stalls the core while a data-bus access is in flight.
module lsu_ctrl
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_result_src_in,
    output logic            o_stall,
    output logic [1:0]      o_result_sel,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_access_err,
    output logic            o_timeout_err,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_be,
    input  logic            i_bus_gnt,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    lsu_state_e      r_state, w_state_d;
    logic [15:0]     r_cnt;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_bus_wdata;
    logic [3:0]      r_bus_be;
    logic [XLEN-1:0] r_load_data;
    logic            r_timeout_err;

    logic            w_access;
    logic            w_illegal;
    logic            w_start;
    logic            w_hit;
    logic            w_abort;
    logic [3:0]      w_st_be;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_ld_data;

    assign w_access  = i_mem_read | i_mem_write;
    assign w_illegal = access_illegal(i_funct3, i_addr[1:0]);
    assign w_start   = !i_rst && (r_state == StIdle) && w_access && !w_illegal;
    assign w_hit     = (r_cnt == CntLast);
    // A grant or read-data arriving on the final allowed cycle still completes normally.
    assign w_abort   = w_hit && (((r_state == StReq) && !i_bus_gnt) ||
                                 ((r_state == StWait) && !i_bus_rvalid));

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_funct3  (i_funct3),
        .i_st_addr_lo (i_addr[1:0]),
        .i_st_wdata   (i_wdata),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_rdata   (i_bus_rdata),
        .o_ld_data    (w_ld_data)
    );

    // Next state, stall, result select and the access-error pulse.
    always_comb begin
        w_state_d    = r_state;
        o_stall      = 1'b0;
        o_access_err = 1'b0;
        o_result_sel = i_result_src_in;
        unique case (r_state)
            StIdle: begin
                if (!i_rst && w_access) begin
                    if (w_illegal) begin
                        o_access_err = 1'b1;
                    end else begin
                        o_stall   = 1'b1;
                        w_state_d = StReq;
                    end
                end
            end
            StReq: begin
                o_stall = 1'b1;
                if (i_bus_gnt) begin
                    w_state_d = r_bus_we ? StDone : StWait;
                end else if (w_abort) begin
                    w_state_d = StDone;
                end
            end
            StWait: begin
                o_stall = 1'b1;
                if (i_bus_rvalid || w_abort) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                // Retire cycle: the stalled instruction writes back now.
                if (!r_bus_we) begin
                    o_result_sel = RES_MEM;
                end
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, access latches, timeout counter and load result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_funct3      <= '0;
            r_addr_lo     <= '0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_be      <= '0;
            r_load_data   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_cnt       <= '0;
                r_funct3    <= i_funct3;
                r_addr_lo   <= i_addr[1:0];
                // Read wins when both strobes are raised.
                r_bus_we    <= !i_mem_read;
                r_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                r_bus_wdata <= i_mem_read ? '0 : w_st_wdata;
                r_bus_be    <= w_st_be;
            end else if ((r_state == StReq) || (r_state == StWait)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == StWait) && i_bus_rvalid) begin
                r_load_data <= w_ld_data;
            end else if (w_abort) begin
                r_load_data   <= '0;
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_bus_req     = (r_state == StReq);
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_be      = r_bus_be;
    assign o_load_data   = r_load_data;
    assign o_timeout_err = r_timeout_err;

endmodule
